// File: rtl/embaralha_pkg.sv
// Shared types and helpers for the 4-number shuffler.
// State enum, LFSR polynomial/seed, LFSR step and swap-index pick.
package embaralha_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHUFFLE,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // Galois step, right shift: feedback taps applied when the
    // bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0])
            s = s ^ LFSR_POLY;
        return s;
    endfunction

    // Scales an 8-bit random value into 0..idx without division:
    // (byte * (idx+1)) >> 8. Product fits in 10 bits (255*4).
    function automatic logic [1:0] pick_j(
        input logic [7:0] lfsr_byte,
        input logic [1:0] idx
    );
        logic [9:0] prod;
        prod = 10'(lfsr_byte) * (10'(idx) + 10'd1);
        return prod[9:8];
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Ports: clk, rst_n, ena (freeze), step, load, load_val, q.
module lfsr16_galois
    import embaralha_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = embaralha_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_VAL;
        else if (ena) begin
            if (load)
                q <= load_val;
            else if (step)
                q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/embaralha_4_num.sv
// Sequential Fisher-Yates shuffle of a 4-element vector, one swap/clock.
// Ports: clk, rst_n, ena, seed_load, seed, in_valid/in_ready/ordenado,
// out_valid/out_ready/desordenado; perm when EMBARALHA_PERM_OUT_EN.
module embaralha_4_num
    import embaralha_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter logic [15:0] SEED_DEFAULT = embaralha_pkg::SEED_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   seed_load,
    input  logic [15:0]            seed,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0][WIDTH-1:0]  ordenado,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0][WIDTH-1:0]  desordenado
`ifdef EMBARALHA_PERM_OUT_EN
    ,
    output logic [3:0][1:0]        perm
`endif
);

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             idx;
    logic [1:0]             j;
    logic [3:0][WIDTH-1:0]  buffer;
    logic                   accept;
    logic                   step;
    logic                   seed_go;
    logic [15:0]            load_val;
    logic [15:0]            lfsr_q;
    logic                   unused_lfsr_hi;

    // rst_n gating keeps in_ready low while reset is held.
    assign in_ready  = rst_n & ena & (state == IDLE);
    assign out_valid = (state == DONE);
    assign desordenado = buffer;

    assign seed_go  = ena & seed_load & (state == IDLE);
    assign load_val = (seed == 16'h0) ? SEED_DEFAULT : seed;
    assign j        = pick_j(lfsr_q[7:0], idx);

    assign unused_lfsr_hi = ^lfsr_q[15:8];

    lfsr16_galois #(
        .RESET_VAL (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .step     (step),
        .load     (seed_go),
        .load_val (load_val),
        .q        (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        if (ena) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = SHUFFLE;
                    end
                end
                SHUFFLE: begin
                    step = 1'b1;
                    if (idx == 2'd1)
                        state_nxt = DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // When j == idx both writes target the same slot with its own
    // value, so the buffer is left unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
            idx    <= 2'd3;
        end else if (accept) begin
            buffer <= ordenado;
            idx    <= 2'd3;
        end else if (step) begin
            buffer[idx] <= buffer[j];
            buffer[j]   <= buffer[idx];
            idx         <= idx - 2'd1;
        end
    end

`ifdef EMBARALHA_PERM_OUT_EN
    // Source-index array swapped in lockstep with the data buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm <= {2'd3, 2'd2, 2'd1, 2'd0};
        end else if (accept) begin
            perm <= {2'd3, 2'd2, 2'd1, 2'd0};
        end else if (step) begin
            perm[idx] <= perm[j];
            perm[j]   <= perm[idx];
        end
    end
`endif

endmodule

// File: tb/tb_embaralha_4_num.sv
// Scoreboard bench for embaralha_4_num against a Fisher-Yates model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_embaralha_4_num;

    localparam int W = 8;

    typedef logic [3:0][W-1:0] vec_t;
    typedef logic [3:0][1:0]   pv_t;

    typedef struct {
        vec_t data;
        pv_t  pm;
        vec_t src;
        int   due;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        ena       = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed      = '0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    vec_t        ordenado  = '0;
    logic        in_ready;
    logic        out_valid;
    vec_t        desordenado;
`ifdef EMBARALHA_PERM_OUT_EN
    pv_t         perm;
    pv_t         last_perm;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        sb[$];
    logic [15:0] m_lfsr = 16'hACE1;
    bit          head_seen  = 1'b0;
    bit          prev_valid = 1'b0;
    bit          rand_bp    = 1'b0;
    vec_t        prev_out;
    vec_t        last_out = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    embaralha_4_num #(
        .WIDTH        (W),
        .SEED_DEFAULT (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .seed_load   (seed_load),
        .seed        (seed),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ordenado    (ordenado),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .desordenado (desordenado)
`ifdef EMBARALHA_PERM_OUT_EN
        ,
        .perm        (perm)
`endif
    );

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        int x;
        x = int'(v);
        if (x % 2 == 1)
            return 16'((x / 2) ^ 32'hB400);
        return 16'(x / 2);
    endfunction

    // Reference shuffle on plain integer arrays.
    function automatic void model(input vec_t v,
                                  output vec_t o,
                                  output pv_t pm);
        int a[4];
        int p[4];
        int jj;
        int t;
        for (int k = 0; k < 4; k++) begin
            a[k] = int'(v[k]);
            p[k] = k;
        end
        for (int i = 3; i >= 1; i--) begin
            jj = (int'(m_lfsr[7:0]) * (i + 1)) / 256;
            t = a[i]; a[i] = a[jj]; a[jj] = t;
            t = p[i]; p[i] = p[jj]; p[jj] = t;
            m_lfsr = m_step(m_lfsr);
        end
        for (int k = 0; k < 4; k++) begin
            o[k]  = W'(a[k]);
            pm[k] = 2'(p[k]);
        end
    endfunction

    function automatic vec_t sorted(input vec_t v);
        vec_t s;
        logic [W-1:0] t;
        s = v;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3 - a; b++)
                if (s[b] > s[b+1]) begin
                    t = s[b]; s[b] = s[b+1]; s[b+1] = t;
                end
        return s;
    endfunction

    // Monitor: latency, hold stability and data at each handshake.
    always @(negedge clk) begin
        exp_t e;
        vec_t mapped;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out actual=valid required=idle");
            end else begin
                if (!head_seen) begin
                    head_seen = 1'b1;
                    check("latency", 64'(cyc), 64'(sb[0].due));
                end else if (prev_valid) begin
                    check("hold_stable", 64'(desordenado), 64'(prev_out));
                end
                if (ena && out_ready) begin
                    e = sb.pop_front();
                    check("data", 64'(desordenado), 64'(e.data));
                    check("multiset", 64'(sorted(desordenado)),
                          64'(sorted(e.src)));
`ifdef EMBARALHA_PERM_OUT_EN
                    check("perm", 64'(perm), 64'(e.pm));
                    for (int k = 0; k < 4; k++)
                        mapped[k] = e.src[perm[k]];
                    check("perm_map", 64'(desordenado), 64'(mapped));
                    last_perm = perm;
`else
                    mapped = '0;
`endif
                    last_out  = desordenado;
                    head_seen = 1'b0;
                end
            end
        end
        prev_valid = rst_n && out_valid && !(ena && out_ready);
        prev_out   = desordenado;
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp)
            out_ready = 1'($urandom_range(0, 1));
    end

    // Called just after a rising edge; returns just after the
    // accepting edge.
    task automatic send(input vec_t v, input bit ld,
                        input logic [15:0] sd, input int extra);
        bit   ok;
        vec_t o;
        pv_t  pm;
        ok        = 1'b0;
        ordenado  = v;
        in_valid  = 1'b1;
        seed_load = ld;
        seed      = sd;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready)
                ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            if (ld)
                m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
            model(v, o, pm);
            sb.push_back('{o, pm, v, cyc + 4 + extra});
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < 4; k++)
            v[k] = W'($urandom);
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1;
        vec_t exp1;
        vec_t r1;
        vec_t held;
        pv_t  p1;
        logic [15:0] s;
        bit   seen;

        v1[0] = 8'd10; v1[1] = 8'd20; v1[2] = 8'd30; v1[3] = 8'd40;
        exp1[0] = 8'd30; exp1[1] = 8'd10;
        exp1[2] = 8'd20; exp1[3] = 8'd40;
        p1[0] = 2'd2; p1[1] = 2'd0; p1[2] = 2'd1; p1[3] = 2'd3;

        ena       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_desordenado", 64'(desordenado), 64'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Known-answer vector from the default seed.
        send(v1, 1'b0, 16'h0, 0);
        drain();
        check("scn1_data", 64'(last_out), 64'(exp1));
`ifdef EMBARALHA_PERM_OUT_EN
        check("scn1_perm", 64'(last_perm), 64'(p1));
`endif

        // Continues from the advanced LFSR.
        send(rand_vec(), 1'b0, 16'h0, 0);
        send(rand_vec(), 1'b0, 16'h0, 0);
        drain();

        // Zero seed falls back to the default.
        send(v1, 1'b1, 16'h0, 0);
        drain();
        check("seed0_data", 64'(last_out), 64'(exp1));

        send(rand_vec(), 1'b1, 16'($urandom), 0);
        drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(rand_vec(), 1'b0, 16'h0, 0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("bp_reach_done", 64'(seen), 64'd1);
        held = desordenado;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_stable", 64'(desordenado), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // ena dropped mid-shuffle gives the same result, 3 cycles late.
        s = 16'($urandom_range(1, 65535));
        v1 = rand_vec();
        send(v1, 1'b1, s, 0);
        drain();
        r1 = last_out;
        send(v1, 1'b1, s, 3);
        ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ena = 1'b1;
        drain();
        check("ena_same", 64'(last_out), 64'(r1));

        // Async reset during SHUFFLE discards the vector.
        v1[0] = 8'd10; v1[1] = 8'd20; v1[2] = 8'd30; v1[3] = 8'd40;
        send(rand_vec(), 1'b0, 16'h0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_desordenado", 64'(desordenado), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        head_seen = 1'b0;
        m_lfsr    = 16'hACE1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(v1, 1'b0, 16'h0, 0);
        drain();
        check("rst_replay", 64'(last_out), 64'(exp1));

        // Randomized traffic with random backpressure and seeds.
        rand_bp = 1'b1;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0)
                send(rand_vec(), 1'b1, 16'($urandom), 0);
            else
                send(rand_vec(), 1'b0, 16'h0, 0);
            drain();
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/embaralha_4_num.md
Name: embaralha_4_num

Overview:
- Inverse companion of the 4-number sorter: takes an ordered 4-element vector and emits a pseudo-random permutation of it.
- Produces test vectors for the sorter, and scrambles data after sorting.
- Sequential Fisher-Yates shuffle: one swap per clock, driven by a 16-bit Galois LFSR.
- valid/ready handshake on both sides; ena gating in the codebase style.

Parameters:
- WIDTH, 8, element width in bits
- SEED_DEFAULT, 16'hACE1, LFSR value after reset; also replaces any loaded seed of zero

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; 0 freezes all state
- seed_load  in  1  load seed into the LFSR
- seed  in  16  seed value
- in_valid  in  1  ordenado valid
- in_ready  out  1  block can accept a vector
- ordenado  in  WIDTH x [3:0]  input vector
- out_valid  out  1  desordenado valid
- out_ready  in  1  consumer accepts the output
- desordenado  out  WIDTH x [3:0]  shuffled vector

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=SEED_DEFAULT, buffer=0, idx=3.
  - Outputs: in_ready=0 during reset, out_valid=0, desordenado=0.
  - Reset mid-shuffle discards the vector.
- FSM states: IDLE, SHUFFLE, DONE.
- in_ready = ena && state==IDLE.
  - Accept on in_valid && in_ready: buf <= ordenado, idx <= 3, go to SHUFFLE.
- SHUFFLE, one step per ena-cycle for idx = 3, 2, 1:
  - j = (lfsr[7:0] * (idx+1)) >> 8, giving a value in 0..idx.
  - Swap buf[idx] and buf[j]; j==idx leaves buf unchanged.
  - lfsr advances once; idx decrements.
  - After the idx=1 step, go to DONE.
- LFSR step (Galois, right shift): lsb=lfsr[0]; lfsr >>= 1; if lsb, lfsr ^= 16'hB400.
  - The LFSR advances only in SHUFFLE steps, which keeps sequences deterministic.
- DONE:
  - out_valid=1; desordenado=buf, held stable until out_valid && out_ready.
  - On that handshake, go to IDLE.
  - in_ready is 0 while in DONE; there is no same-cycle re-accept.
- Latency and throughput:
  - Accept in cycle T gives out_valid in cycle T+4.
  - Minimum period is 5 cycles per vector with out_ready tied high.
- ena=0: no state, lfsr or buffer change. in_ready=0. out_valid and desordenado hold their values, and handshakes are ignored.
- seed_load:
  - Honoured only in IDLE with ena=1: lfsr <= (seed==0) ? SEED_DEFAULT : seed.
  - Ignored in SHUFFLE and DONE.
  - seed_load and accept in the same cycle: the shuffle uses the new seed.
- Invariant: desordenado is always a permutation of the accepted ordenado; element values are never altered.

Optional Feature:
- Macro: EMBARALHA_PERM_OUT_EN.
- Defined:
  - Adds output perm (2 bits x [3:0]) with desordenado[k] == ordenado[perm[k]].
  - perm is tracked by a 2-bit index array swapped alongside buf.
  - Reset value {3,2,1,0}; valid and held under the same out_valid rules.
- Undefined: port and index tracking are absent; data behaviour is identical.

Decomposition:
- Shared package embaralha_pkg:
  - State enum (IDLE, SHUFFLE, DONE).
  - LFSR_POLY = 16'hB400.
  - SEED_DEFAULT constant.
  - Function lfsr_next(logic [15:0]).
  - Function pick_j(lfsr_byte, idx).
- One sub-module is natural: lfsr16_galois.
  - Ports: clk, rst_n, ena, step, load, load_val, q.
  - Reused by future test-vector generators.

Test Plan:
- Reset, seed 16'hACE1, ordenado={10,20,30,40} (idx 0..3), accept at T:
  - out_valid at T+4.
  - desordenado={30,10,20,40}; perm={2,0,1,3} under the macro.
  - lfsr afterwards = 16'h389C.
- Second vector right after the first: shuffle starts from lfsr 16'h389C.
  - Bench model must match exactly.
  - Output multiset equals the input multiset.
- seed_load with seed=0 in IDLE: lfsr becomes 16'hACE1.
  - The first-scenario vector again yields {30,10,20,40}.
- Backpressure, out_ready=0 for 10 cycles in DONE:
  - out_valid stays 1; desordenado is stable; in_ready=0.
  - Release gives a handshake, then IDLE with in_ready=1 the next cycle.
- ena dropped for 3 cycles mid-SHUFFLE:
  - Completion delayed by exactly 3 cycles.
  - Result identical to the undisturbed run.
- rst_n asserted during SHUFFLE:
  - out_valid=0 and desordenado=0 immediately (async).
  - The next accept after release reproduces the first-scenario result.
